accum_alu_seq: RTL and testbench
================================

// Module: accum_alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the combinational accumulator ALU.
//  Takes one op per transaction (accumulator, register operand or zero-extended immediate),
//  registers result, Zero/Carry flags and branch decision.
//  Adds an iterative shift-add multiply and valid/ready flow control, so the
//  datapath can stall on a busy ALU or a stalled writeback stage.
// PARAMETERS
//  WIDTH   8  datapath width in bits (>=4)
//  IMM_W   5  immediate width; zero-extended to WIDTH (IMM_W < WIDTH)
// PORTS
//  Clk         in   1        single clock, all state on rising edge
//  Reset_n     in   1        synchronous, active-low reset
//  InValid     in   1        request valid
//  InReady     out  1        block can accept request this cycle
//  Op          in   4        opcode (alu_pkg::op_e)
//  UseImm      in   1        1: operand = zero-extended Imm; 0: operand = OperandIn
//  AccIn       in   WIDTH    accumulator value
//  OperandIn   in   WIDTH    register operand
//  Imm         in   IMM_W    immediate
//  OutValid    out  1        result valid; held until OutReady
//  OutReady    in   1        consumer accepts result
//  Result      out  WIDTH    registered result
//  Zero        out  1        Result == 0
//  Carry       out  1        ADD carry-out / SUB borrow; 0 for all other ops
//  Branch      out  1        branch taken (BTRU/B); 0 for all other ops
// BEHAVIOUR
//  Reset (Reset_n=0 at edge): state=IDLE; OutValid, Result, Zero, Carry, Branch = 0. Aborts any
//   MUL in progress; pending result is dropped. InReady=0 in reset cycle.
//  Accept = InValid & InReady. Inputs sampled only on accept; ignored otherwise.
//  InReady = (state==IDLE) | (state==DONE & OutReady)  -> back-to-back single-cycle ops, 1/cycle.
//  States: IDLE --accept non-MUL--> DONE; IDLE --accept MUL--> BUSY; BUSY --WIDTH cycles--> DONE;
//   DONE --OutReady & !accept--> IDLE; DONE --OutReady & accept--> DONE (non-MUL) or BUSY (MUL).
//   DONE & !OutReady: hold Result/flags/OutValid stable.
//  Latency: non-MUL, OutValid in cycle after accept; MUL, OutValid WIDTH+1 cycles after accept.
//  Op B = operand (OperandIn or ext Imm). Ops (unsigned, results mod 2^WIDTH):
//   0 ADD A+B (Carry=bit WIDTH)  1 SUB A-B (Carry=borrow, A<B)   2 AND  3 OR  4 XOR
//   5 XORR ^B in bit0, rest 0    6 SLT {0..,A<B}  7 SEQ {0..,A==B}  8 PASS B
//   9 BTGL A with bit B[$clog2(WIDTH)-1:0] inverted; B>=WIDTH -> Result=A unchanged
//   10 LSL A<<B  11 LSR A>>B ; shift amount >= WIDTH -> Result 0
//   12 MUL low WIDTH bits of A*B, shift-add one bit per cycle, WIDTH cycles
//   13 BTRU Branch=(A==1), Result=A  14 B Branch=1, Result=A  15 reserved: Result 0, flags 0
//  Zero computed from final Result for every op incl. MUL/BTRU/B.
//  MUL uncancellable except by reset; InReady=0 throughout BUSY.
// STRUCTURE
//  alu_pkg: op_e enum (values above), state_e {IDLE,BUSY,DONE}, OP_W=4 constant.
//  Sub-module alu_mul_iter #(WIDTH): start/done, shift-add multiplicand/multiplier/product regs,
//   WIDTH-cycle counter; same Clk/Reset_n. Top holds FSM, single-cycle op mux and output regs.
// TESTING (WIDTH=8, IMM_W=5 unless noted)
//  Reset mid-MUL: accept MUL 7*9, drop Reset_n at cycle 3 -> next cycle all outputs 0, IDLE,
//   InReady=1 once Reset_n=1; no stale OutValid.
//  ADD/SUB flags: A=0xF0,B=0x20 ADD -> 0x10,Carry=1,Zero=0; A=0x05,B=0x05 SUB -> 0x00,Zero=1,Carry=0;
//   A=0x03,B=0x05 SUB -> 0xFE,Carry=1.
//  Immediate/shift edge: UseImm=1,Imm=31,A=0x81 ADD -> 0xA0; LSL by Imm=8 -> 0x00,Zero=1;
//   BTGL A=0x00,B=7 -> 0x80; BTGL B=9 -> Result=A.
//  MUL: A=13,B=11 -> OutValid exactly 9 cycles after accept, Result 0x8F; A=0xFF,B=0xFF -> 0x01.
//  Backpressure: 3 back-to-back ADDs with OutReady=0 for 4 cycles -> first result held stable,
//   InReady=0; OutReady=1 -> one result/cycle, order preserved, no loss/duplication.
//  Branch: BTRU A=1 -> Branch=1; A=2 -> Branch=0; B -> Branch=1; next ADD -> Branch=0.
//  Random ops vs reference model at WIDTH=8 and WIDTH=16 with random InValid/OutReady.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the handshaked accumulator ALU.
//   OP_W    : opcode width
//   op_e    : opcode encoding seen on the Op port
//   state_e : control FSM states of accum_alu_seq
//   op_is_mul() : true for the only multi-cycle opcode
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_XORR = 4'd5,
        OP_SLT  = 4'd6,
        OP_SEQ  = 4'd7,
        OP_PASS = 4'd8,
        OP_BTGL = 4'd9,
        OP_LSL  = 4'd10,
        OP_LSR  = 4'd11,
        OP_MUL  = 4'd12,
        OP_BTRU = 4'd13,
        OP_B    = 4'd14,
        OP_RSVD = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // MUL is the only opcode that goes through the iterative multiplier.
    function automatic logic op_is_mul(input logic [OP_W-1:0] op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add multiplier, one multiplier bit per clock, WIDTH clocks.
// The first partial product is folded into the start cycle so that o_done is
// high in the cycle after the WIDTH-th iteration edge.
// Ports:
//   Clk, Reset_n : clock, synchronous active-low reset
//   i_start      : load operands (single-cycle strobe)
//   i_a, i_b     : multiplicand, multiplier
//   o_done       : product valid (one-cycle pulse)
//   o_product    : low WIDTH bits of i_a*i_b
// -----------------------------------------------------------------------------
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_prod;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    // Operand load, shift-add iteration and iteration counter.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_prod   <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_busy   <= 1'b0;
        end else if (i_start) begin
            // iteration 1 happens here: bit 0 of the multiplier
            r_mcand  <= {i_a[WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, i_b[WIDTH-1:1]};
            r_prod   <= i_b[0] ? i_a : {WIDTH{1'b0}};
            r_cnt    <= CNT_ONE;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == CNT_LAST) begin
                r_busy <= 1'b0;
            end else begin
                if (r_mplier[0]) begin
                    r_prod <= r_prod + r_mcand;
                end else begin
                    r_prod <= r_prod;
                end
                r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                r_cnt    <= r_cnt + CNT_ONE;
            end
        end else begin
            r_busy <= 1'b0;
        end
    end

    assign o_done    = r_busy & (r_cnt == CNT_LAST);
    assign o_product = r_prod;

endmodule

// File: rtl/accum_alu_seq.sv
// -----------------------------------------------------------------------------
// accum_alu_seq
// Handshaked accumulator ALU. One op per accepted request; result and flags are
// registered and held until the consumer takes them. MUL runs on alu_mul_iter.
// Ports:
//   Clk, Reset_n          : clock, synchronous active-low reset
//   InValid / InReady     : request handshake
//   Op, UseImm            : opcode, operand select (1 = zero-extended Imm)
//   AccIn, OperandIn, Imm : accumulator, register operand, immediate
//   OutValid / OutReady   : result handshake
//   Result, Zero, Carry, Branch : registered result and flags
// -----------------------------------------------------------------------------
module accum_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMM_W = 5
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [OP_W-1:0]  Op,
    input  logic             UseImm,
    input  logic [WIDTH-1:0] AccIn,
    input  logic [WIDTH-1:0] OperandIn,
    input  logic [IMM_W-1:0] Imm,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Branch
);

    localparam int               SHW   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};

    state_e           r_state;
    op_e              w_op;
    logic [WIDTH-1:0] w_b;
    logic             w_b_big;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_carry;
    logic             w_alu_branch;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod;

    // Ready only while the output register is free or being drained this cycle.
    assign InReady  = Reset_n & ((r_state == IDLE) | ((r_state == DONE) & OutReady));
    assign w_accept = InValid & InReady;
    assign w_is_mul = op_is_mul(Op);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .i_start   (w_accept & w_is_mul),
        .i_a       (AccIn),
        .i_b       (w_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    // Single-cycle operation mux.
    always_comb begin
        w_op         = op_e'(Op);
        w_b          = UseImm ? {{(WIDTH-IMM_W){1'b0}}, Imm} : OperandIn;
        w_b_big      = (w_b >= W_VAL);
        w_alu_res    = ZERO;
        w_alu_carry  = 1'b0;
        w_alu_branch = 1'b0;
        case (w_op)
            OP_ADD:  {w_alu_carry, w_alu_res} = {1'b0, AccIn} + {1'b0, w_b};
            OP_SUB: begin
                w_alu_res   = AccIn - w_b;
                w_alu_carry = (AccIn < w_b);
            end
            OP_AND:  w_alu_res = AccIn & w_b;
            OP_OR:   w_alu_res = AccIn | w_b;
            OP_XOR:  w_alu_res = AccIn ^ w_b;
            OP_XORR: w_alu_res = {{(WIDTH-1){1'b0}}, ^w_b};
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, (AccIn < w_b)};
            OP_SEQ:  w_alu_res = {{(WIDTH-1){1'b0}}, (AccIn == w_b)};
            OP_PASS: w_alu_res = w_b;
            OP_BTGL: begin
                // bit index out of range leaves the accumulator untouched
                if (w_b_big) begin
                    w_alu_res = AccIn;
                end else begin
                    w_alu_res = AccIn ^ (ONE << w_b[SHW-1:0]);
                end
            end
            OP_LSL: begin
                if (w_b_big) begin
                    w_alu_res = ZERO;
                end else begin
                    w_alu_res = AccIn << w_b;
                end
            end
            OP_LSR: begin
                if (w_b_big) begin
                    w_alu_res = ZERO;
                end else begin
                    w_alu_res = AccIn >> w_b;
                end
            end
            OP_BTRU: begin
                w_alu_res    = AccIn;
                w_alu_branch = (AccIn == ONE);
            end
            OP_B: begin
                w_alu_res    = AccIn;
                w_alu_branch = 1'b1;
            end
            default: begin
                // MUL result comes from the multiplier; reserved gives zero
                w_alu_res    = ZERO;
                w_alu_carry  = 1'b0;
                w_alu_branch = 1'b0;
            end
        endcase
    end

    // Control FSM and output registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            OutValid <= 1'b0;
            Result   <= ZERO;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Branch   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state  <= BUSY;
                            OutValid <= 1'b0;
                        end else begin
                            r_state  <= DONE;
                            OutValid <= 1'b1;
                            Result   <= w_alu_res;
                            Zero     <= (w_alu_res == ZERO);
                            Carry    <= w_alu_carry;
                            Branch   <= w_alu_branch;
                        end
                    end else if ((r_state == DONE) && OutReady) begin
                        r_state  <= IDLE;
                        OutValid <= 1'b0;
                    end else begin
                        // DONE without OutReady: everything held stable
                        r_state <= r_state;
                    end
                end
                BUSY: begin
                    if (w_mul_done) begin
                        r_state  <= DONE;
                        OutValid <= 1'b1;
                        Result   <= w_mul_prod;
                        Zero     <= (w_mul_prod == ZERO);
                        Carry    <= 1'b0;
                        Branch   <= 1'b0;
                    end else begin
                        r_state <= BUSY;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    OutValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_accum_alu_seq
// Directed bench for accum_alu_seq (WIDTH=8, IMM_W=5) with a short randomised
// handshake run checked against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_accum_alu_seq;

    localparam int W  = 8;
    localparam int IW = 5;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          InValid;
    logic          InReady;
    logic [3:0]    Op;
    logic          UseImm;
    logic [W-1:0]  AccIn;
    logic [W-1:0]  OperandIn;
    logic [IW-1:0] Imm;
    logic          OutValid;
    logic          OutReady;
    logic [W-1:0]  Result;
    logic          Zero;
    logic          Carry;
    logic          Branch;

    int n_total = 0;
    int n_bad   = 0;

    always #5 Clk = ~Clk;

    accum_alu_seq #(.WIDTH(W), .IMM_W(IW)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .InValid   (InValid),
        .InReady   (InReady),
        .Op        (Op),
        .UseImm    (UseImm),
        .AccIn     (AccIn),
        .OperandIn (OperandIn),
        .Imm       (Imm),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Result    (Result),
        .Zero      (Zero),
        .Carry     (Carry),
        .Branch    (Branch)
    );

    // Count a comparison and report it when it does not match.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Behavioural reference: returns {Branch, Carry, Zero, Result}.
    function automatic logic [10:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  r;
        logic        c;
        logic        br;
        r = 8'h00; c = 1'b0; br = 1'b0;
        case (op)
            4'd0:  begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            4'd1:  begin r = a - b; c = (a < b); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = {7'd0, ^b};
            4'd6:  r = (a < b) ? 8'd1 : 8'd0;
            4'd7:  r = (a == b) ? 8'd1 : 8'd0;
            4'd8:  r = b;
            4'd9:  r = (b >= 8'd8) ? a : (a ^ (8'h01 << b[2:0]));
            4'd10: r = (b >= 8'd8) ? 8'h00 : (a << b);
            4'd11: r = (b >= 8'd8) ? 8'h00 : (a >> b);
            4'd12: begin p = {8'h00, a} * {8'h00, b}; r = p[7:0]; end
            4'd13: begin r = a; br = (a == 8'd1); end
            4'd14: begin r = a; br = 1'b1; end
            default: r = 8'h00;
        endcase
        return {br, c, (r == 8'h00), r};
    endfunction

    // Issue one request with OutReady high and wait (bounded) for the result.
    task automatic run_op(input logic [3:0] op, input logic ui, input logic [7:0] a,
                          input logic [7:0] b, input logic [4:0] imm, output int lat);
        Op = op; UseImm = ui; AccIn = a; OperandIn = b; Imm = imm;
        OutReady = 1'b1; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        lat = 1;
        while (!OutValid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Directed vector: result/flags and latency against hand-computed values.
    task automatic do_vec(input string tag, input logic [3:0] op, input logic ui, input logic [7:0] a,
                          input logic [7:0] b, input logic [4:0] imm, input logic br, input logic c,
                          input logic z, input logic [7:0] res, input int exp_lat);
        int lat;
        run_op(op, ui, a, b, imm, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val(tag, 32'({Branch, Carry, Zero, Result}), 32'({br, c, z, res}));
        tick();
    endtask

    logic [10:0] q[$];
    logic [10:0] exp_v;
    logic [7:0]  b_eff;
    int          stale;
    int          lat;

    initial begin
        Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0; Op = 4'd0; UseImm = 1'b0;
        AccIn = 8'h00; OperandIn = 8'h00; Imm = 5'd0;
        tick();
        tick();
        check_val("rst_state", 32'({OutValid, InReady, Branch, Carry, Zero, Result}), 32'(0));
        Reset_n = 1'b1;
        #1;
        check_val("rst_inready", 32'(InReady), 32'(1));
        tick();

        //      tag      op     ui    A      B      imm    br    c     z     res    lat
        do_vec("add_c",  4'd0,  1'b0, 8'hF0, 8'h20, 5'd0,  1'b0, 1'b1, 1'b0, 8'h10, 1);
        do_vec("sub_z",  4'd1,  1'b0, 8'h05, 8'h05, 5'd0,  1'b0, 1'b0, 1'b1, 8'h00, 1);
        do_vec("sub_b",  4'd1,  1'b0, 8'h03, 8'h05, 5'd0,  1'b0, 1'b1, 1'b0, 8'hFE, 1);
        do_vec("add_im", 4'd0,  1'b1, 8'h81, 8'h00, 5'd31, 1'b0, 1'b0, 1'b0, 8'hA0, 1);
        do_vec("lsl_8",  4'd10, 1'b1, 8'hFF, 8'h00, 5'd8,  1'b0, 1'b0, 1'b1, 8'h00, 1);
        do_vec("btgl7",  4'd9,  1'b0, 8'h00, 8'h07, 5'd0,  1'b0, 1'b0, 1'b0, 8'h80, 1);
        do_vec("btgl9",  4'd9,  1'b0, 8'h5A, 8'h09, 5'd0,  1'b0, 1'b0, 1'b0, 8'h5A, 1);
        do_vec("and",    4'd2,  1'b0, 8'hF0, 8'h3C, 5'd0,  1'b0, 1'b0, 1'b0, 8'h30, 1);
        do_vec("or",     4'd3,  1'b0, 8'hF0, 8'h0F, 5'd0,  1'b0, 1'b0, 1'b0, 8'hFF, 1);
        do_vec("xor",    4'd4,  1'b0, 8'hAA, 8'hFF, 5'd0,  1'b0, 1'b0, 1'b0, 8'h55, 1);
        do_vec("xorr",   4'd5,  1'b0, 8'hFF, 8'h07, 5'd0,  1'b0, 1'b0, 1'b0, 8'h01, 1);
        do_vec("slt1",   4'd6,  1'b0, 8'h03, 8'h05, 5'd0,  1'b0, 1'b0, 1'b0, 8'h01, 1);
        do_vec("slt0",   4'd6,  1'b0, 8'h05, 8'h03, 5'd0,  1'b0, 1'b0, 1'b1, 8'h00, 1);
        do_vec("seq",    4'd7,  1'b0, 8'h05, 8'h05, 5'd0,  1'b0, 1'b0, 1'b0, 8'h01, 1);
        do_vec("pass",   4'd8,  1'b1, 8'h00, 8'hEE, 5'd18, 1'b0, 1'b0, 1'b0, 8'h12, 1);
        do_vec("lsr3",   4'd11, 1'b0, 8'h80, 8'h03, 5'd0,  1'b0, 1'b0, 1'b0, 8'h10, 1);
        do_vec("lsr8",   4'd11, 1'b0, 8'h80, 8'h08, 5'd0,  1'b0, 1'b0, 1'b1, 8'h00, 1);
        do_vec("mul_a",  4'd12, 1'b0, 8'd13, 8'd11, 5'd0,  1'b0, 1'b0, 1'b0, 8'h8F, 9);
        do_vec("mul_ff", 4'd12, 1'b0, 8'hFF, 8'hFF, 5'd0,  1'b0, 1'b0, 1'b0, 8'h01, 9);
        do_vec("btru1",  4'd13, 1'b0, 8'h01, 8'h00, 5'd0,  1'b1, 1'b0, 1'b0, 8'h01, 1);
        do_vec("btru2",  4'd13, 1'b0, 8'h02, 8'h00, 5'd0,  1'b0, 1'b0, 1'b0, 8'h02, 1);
        do_vec("br",     4'd14, 1'b0, 8'h33, 8'h00, 5'd0,  1'b1, 1'b0, 1'b0, 8'h33, 1);
        do_vec("add_nb", 4'd0,  1'b0, 8'h01, 8'h01, 5'd0,  1'b0, 1'b0, 1'b0, 8'h02, 1);

        // reserved opcode: result and carry/branch cleared
        run_op(4'd15, 1'b0, 8'hFF, 8'hFF, 5'd0, lat);
        check_val("rsvd", 32'({Branch, Carry, Result}), 32'(0));
        tick();
        do_vec("add_pre", 4'd0, 1'b0, 8'h20, 8'h22, 5'd0,  1'b0, 1'b0, 1'b0, 8'h42, 1);

        // reset in the middle of a MUL
        Op = 4'd12; UseImm = 1'b0; AccIn = 8'd7; OperandIn = 8'd9; OutReady = 1'b1; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        tick();
        tick();
        Reset_n = 1'b0;
        tick();
        check_val("rst_mul", 32'({OutValid, InReady, Branch, Carry, Zero, Result}), 32'(0));
        Reset_n = 1'b1;
        #1;
        check_val("rst_mul_rdy", 32'(InReady), 32'(1));
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (OutValid) stale++;
        end
        check_val("rst_mul_stale", 32'(stale), 32'(0));

        // backpressure: three back-to-back ADDs, consumer stalled four cycles
        Op = 4'd0; UseImm = 1'b0; AccIn = 8'd1; OperandIn = 8'd1; OutReady = 1'b0; InValid = 1'b1;
        tick();
        OperandIn = 8'd2;
        for (int i = 0; i < 4; i++) begin
            check_val("bp_hold", 32'({OutValid, InReady, Result}), 32'({1'b1, 1'b0, 8'd2}));
            tick();
        end
        OutReady = 1'b1;
        tick();
        check_val("bp_r2", 32'({OutValid, Result}), 32'({1'b1, 8'd3}));
        OperandIn = 8'd3;
        tick();
        check_val("bp_r3", 32'({OutValid, Result}), 32'({1'b1, 8'd4}));
        InValid = 1'b0;
        tick();
        check_val("bp_end", 32'(OutValid), 32'(0));

        // random ops and handshakes against the reference model
        for (int cyc = 0; cyc < 400; cyc++) begin
            OutReady  = 1'($urandom_range(0, 1));
            InValid   = 1'($urandom_range(0, 1));
            Op        = 4'($urandom_range(0, 14));
            UseImm    = 1'($urandom_range(0, 1));
            AccIn     = 8'($urandom);
            OperandIn = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            Imm       = 5'($urandom);
            #1;
            if (OutValid && OutReady) begin
                check_val("rnd_pending", 32'(q.size() != 0), 32'(1));
                if (q.size() != 0) begin
                    exp_v = q.pop_front();
                    check_val("rnd_res", 32'({Branch, Carry, Zero, Result}), 32'(exp_v));
                end
            end
            if (InValid && InReady) begin
                b_eff = UseImm ? {3'b000, Imm} : OperandIn;
                q.push_back(ref_alu(Op, AccIn, b_eff));
            end
            tick();
        end

        // drain anything still in flight
        InValid = 1'b0;
        OutReady = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (OutValid && q.size() != 0) begin
                exp_v = q.pop_front();
                check_val("rnd_drain", 32'({Branch, Carry, Zero, Result}), 32'(exp_v));
            end
            tick();
        end
        check_val("rnd_empty", 32'(q.size()), 32'(0));
        check_val("rnd_idle", 32'({OutValid, InReady}), 32'({1'b0, 1'b1}));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
